noc_router_output_arbiter: RTL and testbench
============================================

// Module: noc_router_output_arbiter
// PURPOSE
//  Output stage downstream of the router input ports. One instance per output port.
//  Each input port presents a buffered 13-bit packet and its computed route.
//  The block round-robin arbitrates the inputs whose route equals PORT_ID, registers the winner,
//  and presents it on a valid/ready link to the next router or sink.
// PARAMETERS
//  NUM_IN   4    number of competing input ports (2..8)
//  PORT_ID  0    route code served by this instance (0..3)
//  CNT_W    16   width of statistics counters (used only with NOC_ARB_STATS_EN)
// PORTS
//  clk          in   1           single clock, rising edge
//  reset        in   1           synchronous, active-high
//  req_valid    in   NUM_IN      input i holds a packet
//  req_packet   in   NUM_IN*13   packet from input i; [12:11]=dest
//  req_route    in   NUM_IN*2    route from input i
//  in_ready     out  NUM_IN      one-hot; input i's packet is taken this cycle
//  out_valid    out  1           out_packet is valid
//  out_packet   out  13          registered winning packet
//  out_src      out  $clog2(NUM_IN)  index of the input that supplied out_packet
//  out_ready    in   1           downstream accepts out_packet
//  grant_cnt    out  NUM_IN*CNT_W   per-input accepted packets (NOC_ARB_STATS_EN only)
//  stall_cnt    out  CNT_W       cycles with out_valid && !out_ready (NOC_ARB_STATS_EN only)
// BEHAVIOUR
//  - Clock and reset: one clock (clk). Reset is synchronous, active-high (reset).
//  - Reset values: out_valid=0, out_packet=0, out_src=0, rr_ptr=0, counters=0.
//    in_ready=0 while reset is high.
//  - Eligibility: elig[i] = req_valid[i] && (req_route[i]==PORT_ID).
//  - Load condition: load = !out_valid || out_ready. The output register is empty or drains this cycle.
//  - Winner: when load && |elig, the winner is the first eligible index scanning rr_ptr, rr_ptr+1, ...
//    The scan wraps modulo NUM_IN.
//    in_ready[winner]=1 combinationally; all other bits are 0.
//  - On that edge: out_packet<=req_packet[winner], out_src<=winner, out_valid<=1.
//    rr_ptr<=(winner+1) mod NUM_IN.
//  - load && !|elig: out_valid<=0. rr_ptr holds. out_packet holds its last value.
//  - !load (output full and stalled): all registers hold; in_ready=0.
//  - Latency: 1 cycle from accept to out_valid. Sustained throughput is 1 packet/cycle
//    while out_ready=1.
//  - Combinational path: out_ready -> in_ready. No path from in_ready to req_*.
//  - Ineligible inputs (route!=PORT_ID) never receive in_ready, even if they are the only valid ones.
//  - Fairness: with all NUM_IN inputs continuously eligible, each input is granted exactly once
//    in every NUM_IN consecutive grants.
//  - Packets are never modified, duplicated or dropped.
//    Exception: reset asserted mid-operation discards the held packet.
//  - Downstream stability: while out_valid && !out_ready, out_packet and out_src are stable.
// CONFIGURATION
//  NOC_ARB_STATS_EN defined:
//    - grant_cnt[i] increments on every cycle in_ready[i]=1.
//    - stall_cnt increments each cycle out_valid && !out_ready.
//    - Both counters saturate at all-ones and clear on reset.
//  NOC_ARB_STATS_EN undefined: grant_cnt/stall_cnt ports and logic are absent;
//    all other behaviour is identical.
// STRUCTURE
//  noc_pkg (shared):
//    - PKT_W=13, DEST_MSB=12, DEST_LSB=11
//    - typedef logic [PKT_W-1:0] noc_pkt_t
//    - typedef logic [1:0] noc_route_t
//    - NUM_PORTS=4
//  Sub-module noc_rr_arbiter #(N):
//    - inputs req[N], ptr, en
//    - outputs gnt one-hot and gnt_idx
//    - purely combinational
//  The pointer register, the output register and the stats counters live in the top module.
// TESTING
//  1. Reset, then single request: PORT_ID=2, req_valid=4'b0001, route0=2, packet0=13'h1A5, out_ready=1.
//     Expect in_ready=0001 same cycle, and next cycle out_valid=1, out_packet=13'h1A5, out_src=0.
//  2. Route filter: req_valid=4'b1111, routes={1,3,2,0} (inputs 3..0), PORT_ID=2.
//     Expect only input 1 granted; out_valid stays 0 if no input routes to 2.
//  3. Round-robin: all 4 inputs eligible, out_ready=1 for 8 cycles.
//     Expect out_src sequence 0,1,2,3,0,1,2,3.
//  4. Backpressure: out_valid=1 with out_packet=13'h0F0, then out_ready=0 for 3 cycles.
//     Expect in_ready=0 and out_packet held at 13'h0F0.
//     On out_ready=1, the next winner loads in the same cycle.
//  5. Wrap and skip: rr_ptr=3, only inputs 3 and 1 eligible.
//     Expect grant 3, then grant 1 (not 0/2).
//  6. Reset mid-stall: out_valid=1, out_ready=0, reset pulse.
//     Expect out_valid=0 and rr_ptr=0; with NOC_ARB_STATS_EN, grant_cnt and stall_cnt read 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet/route types and field positions used by the router stages.
package noc_pkg;
  localparam int PKT_W     = 13;
  localparam int DEST_MSB  = 12;
  localparam int DEST_LSB  = 11;
  localparam int NUM_PORTS = 4;

  typedef logic [PKT_W-1:0] noc_pkt_t;
  typedef logic [1:0]       noc_route_t;
endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request scanning ptr, ptr+1, ... modulo N.
module noc_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int IDX_W = $clog2(N);

  int               idx;
  logic [IDX_W-1:0] sel;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      sel = IDX_W'(idx);
      if (en && !found && req[sel]) begin
        found   = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx = sel;
      end
    end
  end
endmodule

// File: rtl/noc_router_output_arbiter.sv
// Router output stage: round-robin picks among inputs routed to PORT_ID into a valid/ready output register.
// Optional statistics counters are built when NOC_ARB_STATS_EN is defined.
module noc_router_output_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int PORT_ID = 0,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IN-1:0]         req_valid,
  input  logic [NUM_IN*PKT_W-1:0]   req_packet,
  input  logic [NUM_IN*2-1:0]       req_route,
  output logic [NUM_IN-1:0]         in_ready,
  output logic                      out_valid,
  output logic [PKT_W-1:0]          out_packet,
  output logic [$clog2(NUM_IN)-1:0] out_src,
  input  logic                      out_ready
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [NUM_IN*CNT_W-1:0]   grant_cnt,
  output logic [CNT_W-1:0]          stall_cnt
`endif
);
  localparam int IDX_W = $clog2(NUM_IN);
  typedef logic [CNT_W-1:0] cnt_t;

  noc_pkt_t         pkt [NUM_IN];
  logic [NUM_IN-1:0] elig;
  logic [NUM_IN-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic [IDX_W-1:0]  rr_ptr;
  logic              load;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign pkt[i]  = req_packet[i*PKT_W +: PKT_W];
    assign elig[i] = req_valid[i] && (req_route[i*2 +: 2] == noc_route_t'(PORT_ID));
  end

  // Output register is free when empty or draining; this is the only out_ready -> in_ready path.
  assign load = !out_valid || out_ready;

  noc_rr_arbiter #(.N(NUM_IN)) u_arb (
    .req     (elig),
    .ptr     (rr_ptr),
    .en      (load && !reset),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign in_ready = gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_packet <= '0;
      out_src    <= '0;
      rr_ptr     <= '0;
    end else if (load) begin
      if (|gnt) begin
        out_valid  <= 1'b1;
        out_packet <= pkt[gnt_idx];
        out_src    <= gnt_idx;
        rr_ptr     <= (gnt_idx == IDX_W'(NUM_IN-1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef NOC_ARB_STATS_EN
  cnt_t gcnt [NUM_IN];
  cnt_t scnt;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_gcnt
    assign grant_cnt[i*CNT_W +: CNT_W] = gcnt[i];
    always_ff @(posedge clk) begin
      if (reset) gcnt[i] <= '0;
      else if (in_ready[i] && !(&gcnt[i])) gcnt[i] <= gcnt[i] + 1'b1;
    end
  end

  assign stall_cnt = scnt;

  always_ff @(posedge clk) begin
    if (reset) scnt <= '0;
    else if (out_valid && !out_ready && !(&scnt)) scnt <= scnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_noc_router_output_arbiter.sv
// Directed bench for noc_router_output_arbiter (NUM_IN=4, PORT_ID=2) with a reference model checked every cycle.
module tb_noc_router_output_arbiter;
  localparam int N   = 4;
  localparam int PID = 2;
  localparam int PW  = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*PW-1:0] req_packet;
  logic [N*2-1:0]  req_route;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [PW-1:0] out_packet;
  logic [1:0]    out_src;
  logic          out_ready;
`ifdef NOC_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0]     stall_cnt;
`endif

  noc_router_output_arbiter #(.NUM_IN(N), .PORT_ID(PID), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_packet (req_packet),
    .req_route  (req_route),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_packet (out_packet),
    .out_src    (out_src),
    .out_ready  (out_ready)
`ifdef NOC_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit          m_on = 0;
  bit          m_valid;
  logic [PW-1:0] m_pkt;
  int          m_src;
  int          m_ptr;
  int          m_gcnt [N];
  int          m_scnt;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int model_winner();
    int idx;
    if (reset) return -1;
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (req_valid[idx] && (req_route[idx*2 +: 2] == 2'(PID))) return idx;
    end
    return -1;
  endfunction

  task automatic set_in(int i, logic v, logic [1:0] r, logic [PW-1:0] p);
    req_valid[i]          = v;
    req_route[i*2 +: 2]   = r;
    req_packet[i*PW +: PW] = p;
  endtask

  task automatic settle();
    int w;
    logic [N-1:0] exp_ir;
    #2;
    if (m_on) begin
      w = model_winner();
      exp_ir = '0;
      if (w >= 0) exp_ir[w] = 1'b1;
      chk("model_in_ready", in_ready, exp_ir);
      chk("model_out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("model_out_packet", out_packet, m_pkt);
        chk("model_out_src", out_src, m_src);
      end
`ifdef NOC_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("model_grant_cnt", grant_cnt[i*16 +: 16], m_gcnt[i]);
      chk("model_stall_cnt", stall_cnt, m_scnt);
`endif
    end
  endtask

  task automatic edge_upd();
    int w;
    @(posedge clk);
    w = model_winner();
    if (reset) begin
      m_valid = 0; m_pkt = '0; m_src = 0; m_ptr = 0; m_scnt = 0;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
      m_on = 1;
    end else begin
      if (m_valid && !out_ready && m_scnt < 65535) m_scnt++;
      if (w >= 0 && m_gcnt[w] < 65535) m_gcnt[w]++;
      if (!m_valid || out_ready) begin
        if (w >= 0) begin
          m_valid = 1; m_pkt = req_packet[w*PW +: PW]; m_src = w; m_ptr = (w + 1) % N;
        end else begin
          m_valid = 0;
        end
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    edge_upd();
  endtask

  int seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    reset = 1'b1; out_ready = 1'b1;
    req_valid = '0; req_packet = '0; req_route = '0;
    cyc(); cyc();
    reset = 1'b0;
    settle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_packet", out_packet, 0);
    chk("rst_out_src", out_src, 0);
    edge_upd();

    // Single request
    set_in(0, 1, 2, 13'h1A5);
    settle();
    chk("t1_in_ready", in_ready, 4'b0001);
    edge_upd();
    req_valid = '0;
    settle();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_packet", out_packet, 13'h1A5);
    chk("t1_out_src", out_src, 0);
    edge_upd();

    // Route filter: routes {1,3,2,0} for inputs 3..0
    set_in(3, 1, 1, 13'h0333);
    set_in(2, 1, 3, 13'h0222);
    set_in(1, 1, 2, 13'h0111);
    set_in(0, 1, 0, 13'h0000);
    settle();
    chk("t2_in_ready", in_ready, 4'b0010);
    edge_upd();
    set_in(1, 1, 0, 13'h0111);
    settle();
    chk("t2_none_in_ready", in_ready, 4'b0000);
    chk("t2_out_src", out_src, 1);
    edge_upd();
    settle();
    chk("t2_out_valid_low", out_valid, 0);
    edge_upd();

    // Round-robin from a fresh pointer
    reset = 1'b1; cyc(); reset = 1'b0;
    for (int i = 0; i < N; i++) set_in(i, 1, 2, PW'(13'h100 + i));
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("t3_out_src", out_src, seq[k]);
    end

    // Backpressure
    req_valid = '0;
    set_in(0, 1, 2, 13'h0F0);
    cyc();
    out_ready = 1'b0;
    set_in(0, 1, 2, 13'h0F1);
    for (int i = 1; i < N; i++) set_in(i, 1, 2, PW'(13'h100 + i));
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t4_in_ready_stall", in_ready, 4'b0000);
      chk("t4_out_packet_hold", out_packet, 13'h0F0);
      edge_upd();
    end
    out_ready = 1'b1;
    settle();
    chk("t4_in_ready_release", in_ready, 4'b0010);
    edge_upd();
    req_valid = '0;
    set_in(2, 1, 2, 13'h0222);
    settle();
    chk("t4_next_packet", out_packet, 13'h101);
    chk("t4_next_src", out_src, 1);
    edge_upd();

    // Wrap and skip with pointer at 3
    req_valid = '0;
    set_in(3, 1, 2, 13'h1333);
    set_in(1, 1, 2, 13'h0111);
    settle();
    chk("t5_grant3", in_ready, 4'b1000);
    edge_upd();
    settle();
    chk("t5_grant1", in_ready, 4'b0010);
    chk("t5_pkt3", out_packet, 13'h1333);
    edge_upd();
    req_valid = '0;
    settle();
    chk("t5_pkt1", out_packet, 13'h0111);
    chk("t5_src1", out_src, 1);

    // Reset during a stall
    out_ready = 1'b0;
    edge_upd();
    for (int i = 0; i < N; i++) set_in(i, 1, 2, PW'(13'h040 + i));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    settle();
    chk("t6_out_valid", out_valid, 0);
    chk("t6_ptr_zero", in_ready, 4'b0001);
`ifdef NOC_ARB_STATS_EN
    chk("t6_grant_cnt", grant_cnt, 0);
    chk("t6_stall_cnt", stall_cnt, 0);
`endif
    edge_upd();
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
